// File: rtl/reservation_station_pkg.sv
// Shared sizes, opcode encodings, entry layout and the CDB snoop helper
// used by the ALU reservation station.
package reservation_station_pkg;

  localparam int RS_SIZE = 8;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int IDX_W   = $clog2(RS_SIZE);

  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_XOR   = 6'd4,
    OP_SLL   = 6'd5,
    OP_SRL   = 6'd6,
    OP_SRA   = 6'd7,
    OP_SLT   = 6'd8,
    OP_SLTU  = 6'd9,
    OP_LUI   = 6'd10,
    OP_AUIPC = 6'd11,
    OP_JAL   = 6'd12,
    OP_JALR  = 6'd13,
    OP_BEQ   = 6'd14,
    OP_BNE   = 6'd15
  } aluOp_e;

  typedef struct packed {
    logic [TAG_W-1:0] q;
    logic [31:0]      v;
  } operand_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    operand_t         j;
    operand_t         k;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } rsEntry_t;

  // A pending operand takes the value of a matching CDB; the ALU CDB wins a tie.
  function automatic operand_t snoop(
    input operand_t         cur,
    input logic             aluValid,
    input logic [TAG_W-1:0] aluTag,
    input logic [31:0]      aluValue,
    input logic             lsbValid,
    input logic [TAG_W-1:0] lsbTag,
    input logic [31:0]      lsbValue
  );
    operand_t res;
    res = cur;
    if (cur.q != NO_TAG) begin
      if (aluValid && (aluTag == cur.q)) begin
        res.q = NO_TAG;
        res.v = aluValue;
      end else if (lsbValid && (lsbTag == cur.q)) begin
        res.q = NO_TAG;
        res.v = lsbValue;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scanning downward lets the lowest set index overwrite the higher ones.
  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched instructions, snoops both CDBs
// for missing operands and issues the lowest-index ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             dsp_valid,
  input  logic [OP_W-1:0]  dsp_op,
  input  logic [TAG_W-1:0] dsp_tag,
  input  logic [31:0]      dsp_vj,
  input  logic [31:0]      dsp_vk,
  input  logic [TAG_W-1:0] dsp_qj,
  input  logic [TAG_W-1:0] dsp_qk,
  input  logic [31:0]      dsp_imm,
  input  logic [31:0]      dsp_pc,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [31:0]      cdb_lsb_value,
  output logic             alu_valid,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_tag
);

  rsEntry_t r_ent [RS_SIZE];

  logic             r_alu_valid;
  logic [OP_W-1:0]  r_alu_op;
  logic [31:0]      r_alu_a;
  logic [31:0]      r_alu_b;
  logic [31:0]      r_alu_imm;
  logic [31:0]      r_alu_pc;
  logic [TAG_W-1:0] r_alu_tag;

  logic [RS_SIZE-1:0] w_busyVec;
  logic [RS_SIZE-1:0] w_readyVec;
  logic               w_freeFound;
  logic [IDX_W-1:0]   w_freeIdx;
  logic               w_readyFound;
  logic [IDX_W-1:0]   w_readyIdx;
  operand_t           w_dspJ;
  operand_t           w_dspK;

  // Readiness looks only at registered state, so a freshly written entry waits a cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_busyVec[i]  = r_ent[i].busy;
      w_readyVec[i] = r_ent[i].busy && (r_ent[i].j.q == NO_TAG) && (r_ent[i].k.q == NO_TAG);
    end
  end

  assign rs_full = &w_busyVec;

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_freeSel (
    .i_req   (~w_busyVec),
    .o_found (w_freeFound),
    .o_idx   (w_freeIdx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_readySel (
    .i_req   (w_readyVec),
    .o_found (w_readyFound),
    .o_idx   (w_readyIdx)
  );

  always_comb begin
    w_dspJ = snoop('{q: dsp_qj, v: dsp_vj}, cdb_alu_valid, cdb_alu_tag, cdb_alu_value,
                   cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value);
    w_dspK = snoop('{q: dsp_qk, v: dsp_vk}, cdb_alu_valid, cdb_alu_tag, cdb_alu_value,
                   cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_imm   <= '0;
      r_alu_pc    <= '0;
      r_alu_tag   <= '0;
    end else if (!rdy_in) begin
      r_alu_valid <= 1'b0;
    end else if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_imm   <= '0;
      r_alu_pc    <= '0;
      r_alu_tag   <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_ent[i].busy) begin
          r_ent[i].j <= snoop(r_ent[i].j, cdb_alu_valid, cdb_alu_tag, cdb_alu_value,
                              cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value);
          r_ent[i].k <= snoop(r_ent[i].k, cdb_alu_valid, cdb_alu_tag, cdb_alu_value,
                              cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value);
        end
      end
      r_alu_valid <= w_readyFound;
      if (w_readyFound) begin
        r_alu_op                <= r_ent[w_readyIdx].op;
        r_alu_a                 <= r_ent[w_readyIdx].j.v;
        r_alu_b                 <= r_ent[w_readyIdx].k.v;
        r_alu_imm               <= r_ent[w_readyIdx].imm;
        r_alu_pc                <= r_ent[w_readyIdx].pc;
        r_alu_tag               <= r_ent[w_readyIdx].tag;
        r_ent[w_readyIdx].busy  <= 1'b0;
      end
      // The free slot is never busy, so it cannot collide with the issued or captured entries.
      if (dsp_valid && w_freeFound) begin
        r_ent[w_freeIdx] <= '{busy: 1'b1, op: dsp_op, j: w_dspJ, k: w_dspK,
                              imm: dsp_imm, pc: dsp_pc, tag: dsp_tag};
      end
    end
  end

  assign alu_valid = r_alu_valid;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_imm   = r_alu_imm;
  assign alu_pc    = r_alu_pc;
  assign alu_tag   = r_alu_tag;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for the reservation station: directed scenarios plus random
// traffic, checked against a behavioural model of the station's contents.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear_in;
  logic             dsp_valid;
  logic [OP_W-1:0]  dsp_op;
  logic [TAG_W-1:0] dsp_tag, dsp_qj, dsp_qk;
  logic [31:0]      dsp_vj, dsp_vk, dsp_imm, dsp_pc;
  logic             rs_full;
  logic             cdb_alu_valid, cdb_lsb_valid;
  logic [TAG_W-1:0] cdb_alu_tag, cdb_lsb_tag;
  logic [31:0]      cdb_alu_value, cdb_lsb_value;
  logic             alu_valid;
  logic [OP_W-1:0]  alu_op;
  logic [31:0]      alu_a, alu_b, alu_imm, alu_pc;
  logic [TAG_W-1:0] alu_tag;

  always #5 clk_in = ~clk_in;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_tag(dsp_tag),
    .dsp_vj(dsp_vj), .dsp_vk(dsp_vk), .dsp_qj(dsp_qj), .dsp_qk(dsp_qk),
    .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_tag(alu_tag)
  );

  typedef struct {
    bit               busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] qj, qk, tag;
    logic [31:0]      vj, vk, imm, pc;
  } mdlEnt_t;

  typedef struct {
    int               cyc;
    logic [OP_W-1:0]  op;
    logic [31:0]      a, b, imm, pc;
    logic [TAG_W-1:0] tag;
  } expIssue_t;

  mdlEnt_t   mdl [RS_SIZE];
  expIssue_t expQ [$];
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  bit        mdlFull = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value a pending tag would receive from the buses this cycle, ALU bus first.
  function automatic bit cdbHit(input logic [TAG_W-1:0] q, output logic [31:0] val);
    val = '0;
    if (q == 0) return 1'b0;
    if (cdb_alu_valid && cdb_alu_tag == q) begin val = cdb_alu_value; return 1'b1; end
    if (cdb_lsb_valid && cdb_lsb_tag == q) begin val = cdb_lsb_value; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic modelStep();
    int          issueIdx;
    int          freeIdx;
    logic [31:0] val;
    expIssue_t   e;
    issueIdx = -1;
    freeIdx  = -1;
    if (rst_in || (rdy_in && clear_in)) begin
      foreach (mdl[i]) mdl[i].busy = 1'b0;
    end else if (rdy_in) begin
      foreach (mdl[i]) begin
        if (issueIdx < 0 && mdl[i].busy && mdl[i].qj == 0 && mdl[i].qk == 0) issueIdx = i;
        if (freeIdx < 0 && !mdl[i].busy) freeIdx = i;
      end
      foreach (mdl[i]) begin
        if (mdl[i].busy) begin
          if (cdbHit(mdl[i].qj, val)) begin mdl[i].qj = 0; mdl[i].vj = val; end
          if (cdbHit(mdl[i].qk, val)) begin mdl[i].qk = 0; mdl[i].vk = val; end
        end
      end
      if (issueIdx >= 0) begin
        e.cyc = cyc + 1;
        e.op  = mdl[issueIdx].op;
        e.a   = mdl[issueIdx].vj;
        e.b   = mdl[issueIdx].vk;
        e.imm = mdl[issueIdx].imm;
        e.pc  = mdl[issueIdx].pc;
        e.tag = mdl[issueIdx].tag;
        expQ.push_back(e);
        mdl[issueIdx].busy = 1'b0;
      end
      if (dsp_valid && freeIdx >= 0) begin
        mdl[freeIdx].busy = 1'b1;
        mdl[freeIdx].op   = dsp_op;
        mdl[freeIdx].tag  = dsp_tag;
        mdl[freeIdx].imm  = dsp_imm;
        mdl[freeIdx].pc   = dsp_pc;
        mdl[freeIdx].qj   = dsp_qj;
        mdl[freeIdx].vj   = dsp_vj;
        mdl[freeIdx].qk   = dsp_qk;
        mdl[freeIdx].vk   = dsp_vk;
        if (cdbHit(dsp_qj, val)) begin mdl[freeIdx].qj = 0; mdl[freeIdx].vj = val; end
        if (cdbHit(dsp_qk, val)) begin mdl[freeIdx].qk = 0; mdl[freeIdx].vk = val; end
      end
    end
    mdlFull = 1'b1;
    foreach (mdl[i]) if (!mdl[i].busy) mdlFull = 1'b0;
  endtask

  task automatic monitor();
    bit        expNow;
    expIssue_t e;
    checkOutput("rs_full", 32'(rs_full), 32'(mdlFull));
    expNow = (expQ.size() > 0) && (expQ[0].cyc == cyc);
    if (alu_valid === 1'b1) begin
      if (!expNow) begin
        checkOutput("spurious_issue", 32'(alu_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checks++;
        checkOutput("alu_op", 32'(alu_op), 32'(e.op));
        checkOutput("alu_a", alu_a, e.a);
        checkOutput("alu_b", alu_b, e.b);
        checkOutput("alu_imm", alu_imm, e.imm);
        checkOutput("alu_pc", alu_pc, e.pc);
        checkOutput("alu_tag", 32'(alu_tag), 32'(e.tag));
      end
    end else if (expNow) begin
      e = expQ.pop_front();
      checkOutput("missing_issue", 32'(alu_valid), 32'd1);
    end
  endtask

  // Model advances on the same edge the DUT samples; outputs are checked 1ns later.
  always begin
    @(posedge clk_in);
    modelStep();
    cyc++;
    #1;
    monitor();
  end

  task automatic driveDispatch(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                               input logic [31:0] vj, input logic [TAG_W-1:0] qj,
                               input logic [31:0] vk, input logic [TAG_W-1:0] qk);
    dsp_valid = 1'b1;
    dsp_op    = op;
    dsp_tag   = tag;
    dsp_vj    = vj;
    dsp_qj    = qj;
    dsp_vk    = vk;
    dsp_qk    = qk;
    dsp_imm   = $urandom;
    dsp_pc    = $urandom;
  endtask

  // Holds the current inputs for n cycles, then returns strobes to idle.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk_in);
    dsp_valid     = 1'b0;
    cdb_alu_valid = 1'b0;
    cdb_lsb_valid = 1'b0;
    clear_in      = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; dsp_valid = 1'b0;
    dsp_op = '0; dsp_tag = '0; dsp_vj = '0; dsp_vk = '0; dsp_qj = '0; dsp_qk = '0;
    dsp_imm = '0; dsp_pc = '0;
    cdb_alu_valid = 1'b0; cdb_alu_tag = '0; cdb_alu_value = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_tag = '0; cdb_lsb_value = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("rst_alu_valid", 32'(alu_valid), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_tag", 32'(alu_tag), 32'd0);
    checkOutput("rst_rs_full", 32'(rs_full), 32'd0);

    driveDispatch(OP_ADD, 4'd3, 32'd5, 4'd0, 32'd7, 4'd0);
    applyStimulus(1);
    applyStimulus(3);

    driveDispatch(OP_SUB, 4'd2, 32'hDEAD, 4'd4, 32'd1, 4'd0);
    applyStimulus(2);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd4; cdb_alu_value = 32'h10;
    applyStimulus(1);
    applyStimulus(3);

    driveDispatch(OP_XOR, 4'd5, 32'd9, 4'd0, 32'hBEEF, 4'd6);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd6; cdb_lsb_value = 32'hAB;
    applyStimulus(1);
    applyStimulus(3);

    for (int i = 0; i < 9; i++) begin
      driveDispatch(OP_OR, 4'(i + 1), 32'h0, 4'd9, 32'(i), 4'd0);
      applyStimulus(1);
    end
    applyStimulus(1);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd9; cdb_alu_value = 32'h99;
    applyStimulus(1);
    applyStimulus(12);

    for (int i = 0; i < 3; i++) begin
      driveDispatch(OP_AND, 4'(i + 1), 32'h0, 4'd12, 32'h1, 4'd0);
      applyStimulus(1);
    end
    driveDispatch(OP_AND, 4'd7, 32'h1, 4'd0, 32'h1, 4'd0);
    clear_in = 1'b1;
    applyStimulus(1);
    checkOutput("clr_alu_valid", 32'(alu_valid), 32'd0);
    checkOutput("clr_rs_full", 32'(rs_full), 32'd0);
    checkOutput("clr_alu_a", alu_a, 32'd0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd12; cdb_alu_value = 32'h12;
    applyStimulus(1);
    applyStimulus(4);

    driveDispatch(OP_SLT, 4'd8, 32'd21, 4'd0, 32'd22, 4'd0);
    applyStimulus(1);
    driveDispatch(OP_SLL, 4'd10, 32'd1, 4'd0, 32'd0, 4'd13);
    rdy_in = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd13; cdb_alu_value = 32'h13;
    repeat (3) @(negedge clk_in);
    rdy_in = 1'b1;
    applyStimulus(0);
    applyStimulus(3);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd13; cdb_lsb_value = 32'h1313;
    applyStimulus(1);
    applyStimulus(4);

    for (int c = 0; c < 400; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6)
        driveDispatch(OP_W'($urandom_range(0, 63)), TAG_W'($urandom_range(1, 15)), $urandom,
                      ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 15)) : 4'd0,
                      $urandom,
                      ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 15)) : 4'd0);
      cdb_alu_valid = ($urandom_range(0, 9) < 4);
      cdb_alu_tag   = TAG_W'($urandom_range(1, 15));
      cdb_alu_value = $urandom;
      cdb_lsb_valid = ($urandom_range(0, 9) < 4);
      cdb_lsb_tag   = TAG_W'($urandom_range(1, 15));
      cdb_lsb_value = $urandom;
      applyStimulus(1);
    end

    rdy_in = 1'b1;
    for (int t = 1; t < 16; t++) begin
      cdb_alu_valid = 1'b1; cdb_alu_tag = TAG_W'(t); cdb_alu_value = $urandom;
      applyStimulus(1);
    end
    for (int w = 0; w < 50 && expQ.size() > 0; w++) applyStimulus(1);
    applyStimulus(12);
    if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
